coef_ram_arbiter: RTL and testbench

COEF_RAM_ARBITER -- requirements
Module: coef_ram_arbiter

---
 rtl/coef_ram_arbiter.sv | 92 +++++++++
 tb/tb_coef_ram_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/coef_ram_arbiter.sv
// Round-robin arbiter sharing one coefficient RAM between the right and left filters.
// Fixed 3-cycle request-to-data latency; per-sample-period grant counting with overrun flagging.
module coef_ram_arbiter #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              data_en,
   input  logic              req_R,
   input  logic              req_L,
   input  logic [ADDR_W-1:0] addr_R,
   input  logic [ADDR_W-1:0] addr_L,
   output logic              gnt_R,
   output logic              gnt_L,
   output logic [DATA_W-1:0] rdata_R,
   output logic [DATA_W-1:0] rdata_L,
   output logic              rvalid_R,
   output logic              rvalid_L,
   output logic [ADDR_W-1:0] RAM_coefs_addr,
   input  logic [DATA_W-1:0] RAM_coefs_dataout,
   output logic              busy,
   output logic              overrun,
   output logic [7:0]        access_count
);

   logic       prio_l;
   logic       tag2_vld;
   logic       tag2_l;
   logic [7:0] grant_cnt;

   logic       elig_r;
   logic       elig_l;
   logic       win_r;
   logic       win_l;
   logic       pending;
   logic [7:0] cnt_next;

   // A requester whose grant is showing this cycle is not eligible, so a held req is not re-granted.
   always_comb begin
      elig_r   = req_R & ~gnt_R;
      elig_l   = req_L & ~gnt_L;
      win_r    = elig_r & (~elig_l | ~prio_l);
      win_l    = elig_l & (~elig_r | prio_l);
      pending  = (req_R & ~gnt_R & ~win_r) | (req_L & ~gnt_L & ~win_l);
      cnt_next = grant_cnt;
      if ((gnt_R | gnt_L) && (grant_cnt != 8'hFF)) cnt_next = grant_cnt + 8'd1;
   end

   assign busy = req_R | req_L | gnt_R | gnt_L | tag2_vld;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gnt_R          <= 1'b0;
         gnt_L          <= 1'b0;
         prio_l         <= 1'b0;
         RAM_coefs_addr <= '0;
         tag2_vld       <= 1'b0;
         tag2_l         <= 1'b0;
         rvalid_R       <= 1'b0;
         rvalid_L       <= 1'b0;
         rdata_R        <= '0;
         rdata_L        <= '0;
         grant_cnt      <= 8'd0;
         access_count   <= 8'd0;
         overrun        <= 1'b0;
      end else begin
         gnt_R <= win_r;
         gnt_L <= win_l;
         if (win_r) RAM_coefs_addr <= addr_R;
         else if (win_l) RAM_coefs_addr <= addr_L;
         if (win_r | win_l) prio_l <= win_r;

         // gnt_X is the first tag stage; tag2 lines up with RAM data.
         tag2_vld <= gnt_R | gnt_L;
         tag2_l   <= gnt_L;
         rvalid_R <= tag2_vld & ~tag2_l;
         rvalid_L <= tag2_vld & tag2_l;
         if (tag2_vld & ~tag2_l) rdata_R <= RAM_coefs_dataout;
         if (tag2_vld & tag2_l)  rdata_L <= RAM_coefs_dataout;

         if (data_en) begin
            access_count <= cnt_next;
            grant_cnt    <= 8'd0;
            if (pending || (grant_cnt == 8'hFF)) overrun <= 1'b1;
         end else begin
            grant_cnt <= cnt_next;
         end
      end
   end

endmodule

// File: tb/tb_coef_ram_arbiter.sv
// Directed testbench for coef_ram_arbiter with a synchronous RAM model.
module tb_coef_ram_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic       data_en;
   logic       req_R, req_L;
   logic [6:0] addr_R, addr_L;
   logic       gnt_R, gnt_L;
   logic [7:0] rdata_R, rdata_L;
   logic       rvalid_R, rvalid_L;
   logic [6:0] RAM_coefs_addr;
   logic [7:0] RAM_coefs_dataout;
   logic       busy, overrun;
   logic [7:0] access_count;

   int checks = 0;
   int failures = 0;

   coef_ram_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
      .clock(clock), .reset(reset), .data_en(data_en),
      .req_R(req_R), .req_L(req_L), .addr_R(addr_R), .addr_L(addr_L),
      .gnt_R(gnt_R), .gnt_L(gnt_L), .rdata_R(rdata_R), .rdata_L(rdata_L),
      .rvalid_R(rvalid_R), .rvalid_L(rvalid_L),
      .RAM_coefs_addr(RAM_coefs_addr), .RAM_coefs_dataout(RAM_coefs_dataout),
      .busy(busy), .overrun(overrun), .access_count(access_count)
   );

   always #5 clock = ~clock;

   // RAM contents: data = {0,addr} ^ A6, so 05->A3, 10->AC, 20->B2.
   always @(posedge clock) RAM_coefs_dataout <= {1'b0, RAM_coefs_addr} ^ 8'hA6;

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      req_R = 1'b0; req_L = 1'b0; data_en = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req_R = 1'b0; req_L = 1'b0; data_en = 1'b0; addr_R = '0; addr_L = '0;
      repeat (2) tick();
      checks++; if ({gnt_R, gnt_L, rvalid_R, rvalid_L} !== 4'b0) begin failures++; $display("FAIL reset_pulses got %b want 0000", {gnt_R, gnt_L, rvalid_R, rvalid_L}); end
      checks++; if ({rdata_R, rdata_L, RAM_coefs_addr} !== 23'h0) begin failures++; $display("FAIL reset_data got %h want 0", {rdata_R, rdata_L, RAM_coefs_addr}); end
      checks++; if ({busy, overrun, access_count} !== 10'h0) begin failures++; $display("FAIL reset_status got %h want 0", {busy, overrun, access_count}); end
      reset = 1'b1;
   endtask

   task automatic test_single_read();
      do_reset();
      addr_R = 7'h05; req_R = 1'b1;
      tick();
      req_R = 1'b0;
      checks++; if (gnt_R !== 1'b1) begin failures++; $display("FAIL single_gnt_R got %b want 1", gnt_R); end
      checks++; if (RAM_coefs_addr !== 7'h05) begin failures++; $display("FAIL single_addr got %h want 05", RAM_coefs_addr); end
      checks++; if (gnt_L !== 1'b0) begin failures++; $display("FAIL single_gnt_L got %b want 0", gnt_L); end
      tick();
      checks++; if ({gnt_R, rvalid_R, busy} !== 3'b001) begin failures++; $display("FAIL single_t2 got gnt,rvalid,busy=%b want 001", {gnt_R, rvalid_R, busy}); end
      tick();
      checks++; if (rvalid_R !== 1'b1) begin failures++; $display("FAIL single_rvalid_R got %b want 1", rvalid_R); end
      checks++; if (rdata_R !== 8'hA3) begin failures++; $display("FAIL single_rdata_R got %h want a3", rdata_R); end
      checks++; if (rvalid_L !== 1'b0) begin failures++; $display("FAIL single_rvalid_L got %b want 0", rvalid_L); end
      tick();
      checks++; if ({rvalid_R, rdata_R, RAM_coefs_addr, busy} !== {1'b0, 8'hA3, 7'h05, 1'b0}) begin failures++; $display("FAIL single_hold got rv=%b rd=%h addr=%h busy=%b want 0 a3 05 0", rvalid_R, rdata_R, RAM_coefs_addr, busy); end
   endtask

   task automatic test_back_to_back();
      logic er, el, evr, evl;
      do_reset();
      addr_R = 7'd10; addr_L = 7'd20; req_R = 1'b1; req_L = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         er  = (i < 8) && (i % 2 == 0);
         el  = (i < 8) && (i % 2 == 1);
         evr = (i >= 2) && (i < 10) && (i % 2 == 0);
         evl = (i >= 2) && (i < 10) && (i % 2 == 1);
         checks++; if ({gnt_R, gnt_L} !== {er, el}) begin failures++; $display("FAIL b2b_gnt[%0d] got %b want %b", i, {gnt_R, gnt_L}, {er, el}); end
         if (er | el) begin
            checks++; if (RAM_coefs_addr !== (er ? 7'd10 : 7'd20)) begin failures++; $display("FAIL b2b_addr[%0d] got %0d want %0d", i, RAM_coefs_addr, er ? 10 : 20); end
         end
         checks++; if ({rvalid_R, rvalid_L} !== {evr, evl}) begin failures++; $display("FAIL b2b_rvalid[%0d] got %b want %b", i, {rvalid_R, rvalid_L}, {evr, evl}); end
         if (evr) begin
            checks++; if (rdata_R !== 8'hAC) begin failures++; $display("FAIL b2b_rdata_R[%0d] got %h want ac", i, rdata_R); end
         end
         if (evl) begin
            checks++; if (rdata_L !== 8'hB2) begin failures++; $display("FAIL b2b_rdata_L[%0d] got %h want b2", i, rdata_L); end
         end
         if (i == 7) begin req_R = 1'b0; req_L = 1'b0; end
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      req_L = 1'b1;
      tick();
      req_L = 1'b0;
      checks++; if ({gnt_R, gnt_L} !== 2'b01) begin failures++; $display("FAIL rr_lone_L got %b want 01", {gnt_R, gnt_L}); end
      tick();
      req_R = 1'b1; req_L = 1'b1;
      tick();
      req_R = 1'b0;
      checks++; if ({gnt_R, gnt_L} !== 2'b10) begin failures++; $display("FAIL rr_after_L got %b want 10", {gnt_R, gnt_L}); end
      tick();
      req_L = 1'b0;
      checks++; if ({gnt_R, gnt_L} !== 2'b01) begin failures++; $display("FAIL rr_lone_L_next got %b want 01", {gnt_R, gnt_L}); end
      tick();
      req_R = 1'b1;
      tick();
      req_R = 1'b0;
      tick();
      req_R = 1'b1; req_L = 1'b1;
      tick();
      req_R = 1'b0; req_L = 1'b0;
      checks++; if ({gnt_R, gnt_L} !== 2'b01) begin failures++; $display("FAIL rr_after_R got %b want 01", {gnt_R, gnt_L}); end
      repeat (4) tick();
   endtask

   task automatic test_access_count();
      do_reset();
      data_en = 1'b1;
      tick();
      data_en = 1'b0;
      checks++; if (access_count !== 8'd0) begin failures++; $display("FAIL cnt_first got %0d want 0", access_count); end
      req_R = 1'b1; req_L = 1'b1;
      repeat (6) tick();
      req_R = 1'b0; req_L = 1'b0;
      repeat (2) tick();
      data_en = 1'b1;
      tick();
      data_en = 1'b0;
      checks++; if (access_count !== 8'd6) begin failures++; $display("FAIL cnt_six got %0d want 6", access_count); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL cnt_no_overrun got %b want 0", overrun); end
      // grant visible in the data_en cycle is counted into that period
      req_R = 1'b1;
      tick();
      req_R = 1'b0;
      data_en = 1'b1;
      tick();
      data_en = 1'b0;
      checks++; if (access_count !== 8'd1) begin failures++; $display("FAIL cnt_same_cycle got %0d want 1", access_count); end
      repeat (2) tick();
      data_en = 1'b1;
      tick();
      data_en = 1'b0;
      checks++; if (access_count !== 8'd0) begin failures++; $display("FAIL cnt_restart got %0d want 0", access_count); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL cnt_no_overrun2 got %b want 0", overrun); end
   endtask

   task automatic test_saturation();
      do_reset();
      req_R = 1'b1; req_L = 1'b1;
      repeat (260) tick();
      req_R = 1'b0; req_L = 1'b0;
      repeat (3) tick();
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL sat_pre_overrun got %b want 0", overrun); end
      data_en = 1'b1;
      tick();
      data_en = 1'b0;
      checks++; if (access_count !== 8'd255) begin failures++; $display("FAIL sat_count got %0d want 255", access_count); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL sat_overrun got %b want 1", overrun); end
   endtask

   task automatic test_overrun();
      @(negedge clock);
      reset = 1'b0;
      req_R = 1'b1; req_L = 1'b1; data_en = 1'b1;
      #1;
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_reset got %b want 0", overrun); end
      tick();
      reset = 1'b1;
      tick();
      data_en = 1'b0;
      req_R = 1'b0; req_L = 1'b0;
      checks++; if ({gnt_R, overrun} !== 2'b11) begin failures++; $display("FAIL ovr_set got gnt_R,overrun=%b want 11", {gnt_R, overrun}); end
      repeat (5) tick();
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got %b want 1", overrun); end
      do_reset();
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_cleared got %b want 0", overrun); end
   endtask

   task automatic test_reset_inflight();
      do_reset();
      addr_R = 7'h05; req_R = 1'b1;
      tick();
      req_R = 1'b0;
      checks++; if (gnt_R !== 1'b1) begin failures++; $display("FAIL rif_gnt got %b want 1", gnt_R); end
      tick();
      #1 reset = 1'b0;
      #1;
      checks++; if ({gnt_R, gnt_L, rvalid_R, rvalid_L, busy, overrun} !== 6'b0) begin failures++; $display("FAIL rif_async_ctl got %b want 000000", {gnt_R, gnt_L, rvalid_R, rvalid_L, busy, overrun}); end
      checks++; if ({rdata_R, rdata_L, RAM_coefs_addr, access_count} !== 31'h0) begin failures++; $display("FAIL rif_async_data got %h want 0", {rdata_R, rdata_L, RAM_coefs_addr, access_count}); end
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if ({rvalid_R, rvalid_L, busy} !== 3'b000) begin failures++; $display("FAIL rif_no_rvalid[%0d] got %b want 000", i, {rvalid_R, rvalid_L, busy}); end
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_back_to_back();
      test_round_robin();
      test_access_count();
      test_saturation();
      test_overrun();
      test_reset_inflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
